// File: rtl/csel_addsub_pipe.sv
// rtl/csel_addsub_pipe.sv - parametrised pipelined carry-select adder/subtractor
// Input register, then NSTG segments of carry-select blocks, each closed by a register.
module csel_addsub_pipe #(
   parameter int WIDTH = 32,
   parameter int BLK   = 8,
   parameter int NSTG  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             op,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic             ci,
   output logic             out_valid,
   output logic [WIDTH-1:0] out,
   output logic             co,
   output logic             ovf,
   output logic             zero
);
   localparam int BLK_S = (BLK < 1) ? 1 : BLK;
   localparam int NBLK  = WIDTH / BLK_S;
   localparam int NS    = (NSTG < 1) ? 1 : NSTG;
   localparam int BASE  = NBLK / NS;
   localparam int EXTRA = NBLK % NS;
   localparam bit LEGAL = (BLK >= 1) && (WIDTH >= BLK_S) && ((WIDTH % BLK_S) == 0) &&
                          (NSTG >= 1) && (NSTG <= NBLK);

   if (!LEGAL) begin : g_illegal
      $error("csel_addsub_pipe: illegal WIDTH/BLK/NSTG combination");
   end

   // First block of segment s; earlier segments absorb the remainder blocks.
   function automatic int seg_lo(input int s);
      return s * BASE + ((s < EXTRA) ? s : EXTRA);
   endfunction

   // Index 0 is the input register; index s>0 is the boundary in front of segment s.
   logic [WIDTH-1:0] a_r  [NS];
   logic [WIDTH-1:0] b_r  [NS];
   logic [WIDTH-1:0] s_r  [NS];
   logic             c_r  [NS];
   logic             op_r [NS];
   logic             v_r  [NS];

   logic [WIDTH-1:0] b_c  [NS];
   logic [WIDTH-1:0] s_n  [NS];
   logic             c_n  [NS];

   always_comb begin
      logic             carry;
      logic [BLK_S-1:0] ab;
      logic [BLK_S-1:0] bb;
      logic [BLK_S:0]   sum0;
      logic [BLK_S:0]   sum1;
      logic [BLK_S:0]   blk;
      carry = 1'b0;
      ab    = '0;
      bb    = '0;
      sum0  = '0;
      sum1  = '0;
      blk   = '0;
      for (int s = 0; s < NS; s++) begin
         // Subtract is A + ~B + ~ci; later segments already hold the conditioned B.
         if (s == 0) begin
            b_c[s] = op_r[s] ? ~b_r[s] : b_r[s];
            carry  = op_r[s] ^ c_r[s];
         end else begin
            b_c[s] = b_r[s];
            carry  = c_r[s];
         end
         s_n[s] = s_r[s];
         for (int j = seg_lo(s); j < seg_lo(s + 1); j++) begin
            ab   = a_r[s][j*BLK_S +: BLK_S];
            bb   = b_c[s][j*BLK_S +: BLK_S];
            sum0 = {1'b0, ab} + {1'b0, bb};
            sum1 = sum0 + {{BLK_S{1'b0}}, 1'b1};
            if (j == 0)
               blk = sum0 + {{BLK_S{1'b0}}, carry};
            else
               blk = carry ? sum1 : sum0;
            s_n[s][j*BLK_S +: BLK_S] = blk[BLK_S-1:0];
            carry = blk[BLK_S];
         end
         c_n[s] = carry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NS; s++) begin
            a_r[s]  <= '0;
            b_r[s]  <= '0;
            s_r[s]  <= '0;
            c_r[s]  <= 1'b0;
            op_r[s] <= 1'b0;
            v_r[s]  <= 1'b0;
         end
         out_valid <= 1'b0;
         out       <= '0;
         co        <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
      end else begin
         a_r[0]  <= inA;
         b_r[0]  <= inB;
         s_r[0]  <= '0;
         c_r[0]  <= ci;
         op_r[0] <= op;
         v_r[0]  <= in_valid;
         for (int s = 1; s < NS; s++) begin
            a_r[s]  <= a_r[s-1];
            b_r[s]  <= b_c[s-1];
            s_r[s]  <= s_n[s-1];
            c_r[s]  <= c_n[s-1];
            op_r[s] <= op_r[s-1];
            v_r[s]  <= v_r[s-1];
         end
         out       <= s_n[NS-1];
         co        <= op_r[NS-1] ^ c_n[NS-1];
         // With B already conditioned, add and subtract share one overflow rule.
         ovf       <= (a_r[NS-1][WIDTH-1] == b_c[NS-1][WIDTH-1]) &&
                      (s_n[NS-1][WIDTH-1] != a_r[NS-1][WIDTH-1]);
         zero      <= ~|s_n[NS-1];
         out_valid <= v_r[NS-1];
      end
   end
endmodule

// File: tb/tb_csel_addsub_pipe.sv
// tb/tb_csel_addsub_pipe.sv - self-checking bench for csel_addsub_pipe
// Five configurations share one stimulus stream; results are checked against an arithmetic model.
module tb_csel_addsub_pipe;
   localparam int NI = 5;
   localparam int W  [NI] = '{32, 32, 32, 16, 64};
   localparam int NS [NI] = '{1, 2, 4, 1, 3};
   localparam int HN = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        op = 1'b0;
   logic        ci = 1'b0;
   logic [63:0] a64 = '0;
   logic [63:0] b64 = '0;

   logic [NI-1:0] ov, cw, fw, zw;
   logic [31:0]   out0, out1, out2;
   logic [15:0]   out3;
   logic [63:0]   out4;
   logic [63:0]   o_out [NI];

   assign o_out[0] = {32'd0, out0};
   assign o_out[1] = {32'd0, out1};
   assign o_out[2] = {32'd0, out2};
   assign o_out[3] = {48'd0, out3};
   assign o_out[4] = out4;

   always #5 clk = ~clk;

   csel_addsub_pipe #(.WIDTH(32), .BLK(8), .NSTG(1)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .op(op), .inA(a64[31:0]), .inB(b64[31:0]), .ci(ci), .out_valid(ov[0]), .out(out0),
      .co(cw[0]), .ovf(fw[0]), .zero(zw[0]));
   csel_addsub_pipe #(.WIDTH(32), .BLK(8), .NSTG(2)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .op(op), .inA(a64[31:0]), .inB(b64[31:0]), .ci(ci), .out_valid(ov[1]), .out(out1),
      .co(cw[1]), .ovf(fw[1]), .zero(zw[1]));
   csel_addsub_pipe #(.WIDTH(32), .BLK(8), .NSTG(4)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .op(op), .inA(a64[31:0]), .inB(b64[31:0]), .ci(ci), .out_valid(ov[2]), .out(out2),
      .co(cw[2]), .ovf(fw[2]), .zero(zw[2]));
   csel_addsub_pipe #(.WIDTH(16), .BLK(8), .NSTG(1)) u3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .op(op), .inA(a64[15:0]), .inB(b64[15:0]), .ci(ci), .out_valid(ov[3]), .out(out3),
      .co(cw[3]), .ovf(fw[3]), .zero(zw[3]));
   csel_addsub_pipe #(.WIDTH(64), .BLK(16), .NSTG(3)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .op(op), .inA(a64), .inB(b64), .ci(ci), .out_valid(ov[4]), .out(out4),
      .co(cw[4]), .ovf(fw[4]), .zero(zw[4]));

   logic          h_v  [HN];
   logic          h_op [HN];
   logic          h_c  [HN];
   logic [63:0]   h_a  [HN];
   logic [63:0]   h_b  [HN];
   logic [NI-1:0] h_dm [HN];
   logic [63:0]   h_xo [HN];
   logic [2:0]    h_xf [HN];
   int cyc = 0;
   int tests = 0;
   int fails = 0;

   // Returns {result[63:0], co, ovf, zero} from integer arithmetic on w-bit operands.
   function automatic logic [66:0] model(input int w, input logic [63:0] a_in, b_in, input logic c, o);
      logic [63:0]        mask, a, b, r;
      logic signed [67:0] m, ua, ub, sa, sb, cc, ur, sr;
      logic               cout, v;
      mask = ~64'd0 >> (64 - w);
      a    = a_in & mask;
      b    = b_in & mask;
      m    = 68'sd1 <<< w;
      ua   = $signed({4'd0, a});
      ub   = $signed({4'd0, b});
      cc   = $signed({67'd0, c});
      sa   = a[w-1] ? ua - m : ua;
      sb   = b[w-1] ? ub - m : ub;
      ur   = o ? ua - ub - cc : ua + ub + cc;
      sr   = o ? sa - sb - cc : sa + sb + cc;
      r    = 64'(ur < 0 ? ur + m : (ur >= m ? ur - m : ur));
      cout = o ? (ur < 0) : (ur >= m);
      v    = (sr < -(m >>> 1)) || (sr >= (m >>> 1));
      return {r, cout, v, r == 64'd0};
   endfunction

   function automatic logic [63:0] r64();
      return {$urandom(), $urandom()};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset();
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("rst_u%0d_out@%0d", i, cyc), o_out[i], 64'd0);
         chk($sformatf("rst_u%0d_co@%0d", i, cyc), {63'd0, cw[i]}, 64'd0);
         chk($sformatf("rst_u%0d_ovf@%0d", i, cyc), {63'd0, fw[i]}, 64'd0);
         chk($sformatf("rst_u%0d_zero@%0d", i, cyc), {63'd0, zw[i]}, 64'd0);
         chk($sformatf("rst_u%0d_valid@%0d", i, cyc), {63'd0, ov[i]}, 64'd0);
      end
   endtask

   task automatic check_pipe();
      for (int i = 0; i < NI; i++) begin
         int          idx;
         logic        expv;
         logic [66:0] m;
         idx  = cyc - 1 - NS[i];
         expv = (idx >= 0) ? h_v[idx] : 1'b0;
         chk($sformatf("u%0d_valid@%0d", i, cyc), {63'd0, ov[i]}, {63'd0, expv});
         if (expv) begin
            m = model(W[i], h_a[idx], h_b[idx], h_c[idx], h_op[idx]);
            chk($sformatf("u%0d_out@%0d", i, cyc), o_out[i], m[66:3]);
            chk($sformatf("u%0d_co@%0d", i, cyc), {63'd0, cw[i]}, {63'd0, m[2]});
            chk($sformatf("u%0d_ovf@%0d", i, cyc), {63'd0, fw[i]}, {63'd0, m[1]});
            chk($sformatf("u%0d_zero@%0d", i, cyc), {63'd0, zw[i]}, {63'd0, m[0]});
            if (h_dm[idx][i]) begin
               chk($sformatf("u%0d_dir_out@%0d", i, cyc), o_out[i], h_xo[idx]);
               chk($sformatf("u%0d_dir_flags@%0d", i, cyc), {61'd0, cw[i], fw[i], zw[i]}, {61'd0, h_xf[idx]});
            end
         end
      end
   endtask

   // One cycle: check what the DUTs present, then drive and record the next operands.
   task automatic step(input logic v, o, c, input logic [63:0] a, b,
                       input logic [NI-1:0] dm, input logic [63:0] xo, input logic [2:0] xf);
      @(negedge clk);
      check_pipe();
      in_valid  = v;
      op        = o;
      ci        = c;
      a64       = a;
      b64       = b;
      h_v[cyc]  = v;
      h_op[cyc] = o;
      h_c[cyc]  = c;
      h_a[cyc]  = a;
      h_b[cyc]  = b;
      h_dm[cyc] = dm;
      h_xo[cyc] = xo;
      h_xf[cyc] = xf;
      cyc++;
   endtask

   initial begin
      logic [63:0] ra;
      for (int k = 0; k < HN; k++) begin
         h_v[k]  = 1'b0;
         h_dm[k] = '0;
      end

      #1 rst_n = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check_reset();
         in_valid = 1'b1;
         op       = 1'($urandom_range(0, 1));
         ci       = 1'($urandom_range(0, 1));
         a64      = r64();
         b64      = r64();
         cyc++;
      end
      @(posedge clk);
      #1 rst_n = 1'b1;

      step(0, 0, 0, r64(), r64(), '0, '0, '0);
      step(1, 0, 0, 64'h0123_4567_89ab_cdef, 64'h1111_2222_3333_4444, '0, '0, '0);
      repeat (6) step(0, 1, 1, r64(), r64(), '0, '0, '0);

      step(1, 0, 1, 64'hFFFF_FFFF, 64'h0, 5'b00111, 64'h0, 3'b101);
      step(1, 0, 0, 64'h7FFF_FFFF, 64'h1, 5'b00111, 64'h8000_0000, 3'b010);
      step(1, 1, 0, 64'd5, 64'd7, 5'b00111, 64'hFFFF_FFFE, 3'b100);
      step(1, 1, 0, 64'h8000_0000, 64'h1, 5'b00111, 64'h7FFF_FFFF, 3'b010);
      step(1, 1, 1, 64'd9, 64'd4, 5'b00111, 64'd4, 3'b000);
      step(1, 0, 0, 64'h00FF, 64'h0001, 5'b01000, 64'h0100, 3'b000);
      for (int k = 16; k < 64; k += 16) begin
         step(1, 0, 0, (64'd1 << k) - 64'd1, 64'd1, 5'b10000, 64'd1 << k, 3'b000);
         step(1, 1, 0, 64'd1 << k, 64'd1, '0, '0, '0);
      end
      step(1, 0, 0, ~64'd0, 64'd1, 5'b10000, 64'd0, 3'b101);
      repeat (6) step(0, 0, 0, r64(), r64(), '0, '0, '0);

      for (int k = 0; k < 60; k++) begin
         ra = r64();
         step(1, k[0], 1'($urandom_range(0, 1)), ra, ($urandom_range(0, 3) == 0) ? ~ra : r64(), '0, '0, '0);
      end
      for (int k = 0; k < 200; k++) begin
         ra = r64();
         step(1'($urandom_range(0, 1)), k[0], 1'($urandom_range(0, 1)), ra,
              ($urandom_range(0, 3) == 0) ? ~ra : r64(), '0, '0, '0);
      end

      for (int k = 0; k < 3; k++) step(1, k[0], 1'b0, r64(), r64(), '0, '0, '0);
      step(0, 0, 0, r64(), r64(), '0, '0, '0);
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      for (int k = 0; k < cyc; k++) h_v[k] = 1'b0;
      step(1, 1, 1, 64'd100, 64'd58, 5'b11111, 64'd41, 3'b000);
      repeat (7) step(0, 0, 0, r64(), r64(), '0, '0, '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/csel_addsub_pipe.md
Name: csel_addsub_pipe

Overview:
Parametrised, pipelined carry-select adder/subtractor. It is the successor to the team's fixed 16-bit, 2-cycle registered carry-select adder, and adds:
- configurable width, block size and pipeline depth
- subtract mode with borrow
- signed overflow and zero flags
- a valid pipeline
It sits in the datapath wherever a registered wide add/sub with a fixed, known latency is needed.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of BLK.
BLK, 8, carry-select block width. Block 0 is a plain ripple-carry block. Every other block computes both ci=0 and ci=1 and selects with the incoming carry.
NSTG, 1, number of pipeline segments the block chain is split into; 1 <= NSTG <= WIDTH/BLK. Blocks are distributed as evenly as possible, with earlier segments taking any extra block.

Ports:
clk      in   1      rising-edge clock
rst_n    in   1      asynchronous active-low reset
in_valid in   1      operands valid this cycle
op       in   1      0 = add, 1 = subtract
inA      in   WIDTH  operand A
inB      in   WIDTH  operand B
ci       in   1      carry-in (add) / borrow-in (sub)
out_valid out 1      result valid
out      out  WIDTH  result
co       out  1      carry-out (add) / borrow-out (sub)
ovf      out  1      signed two's-complement overflow
zero     out  1      out == 0

Behaviour:
- Reset:
  - rst_n low asynchronously clears every register: input stage, all segment registers, all valid bits, out, co, ovf, zero, out_valid.
  - First capture is on the first rising clk after rst_n deasserts.
- Input stage:
  - inA, inB, ci, op and in_valid are registered on every rising edge, with no enable.
  - Data is captured regardless of in_valid; the valid bit travels alongside it.
- Operand conditioning, after the input register:
  - add: B' = inB, c0 = ci.
  - sub: B' = ~inB, c0 = ~ci, giving A - B - ci.
- Segments:
  - Segment s resolves its blocks using the carry from segment s-1, registered at the boundary.
  - Not-yet-consumed operand bits and already-resolved sum bits are delay-matched through each boundary register.
  - Per-stage op is carried along for the final flags.
- Latency:
  - Operands presented with in_valid=1 before rising edge k appear on out with out_valid=1 after edge k+NSTG.
  - NSTG=1 therefore gives the legacy 2-edge latency (input register plus output register).
- Throughput: one operation per cycle, with no bubbles and no backpressure.
- Outputs, registered:
  - out = WIDTH-bit sum, wrap-around modulo 2^WIDTH.
  - co: add gives the final carry. Sub gives the inverted final carry, so co=1 means borrow (unsigned A < B+ci).
  - ovf: add gives (A[msb]==B[msb]) && (sum[msb]!=A[msb]). Sub gives (A[msb]!=B[msb]) && (sum[msb]!=A[msb]).
  - zero = ~|out.
- Valid handling:
  - out_valid is in_valid delayed by NSTG+1 edges.
  - out/co/ovf/zero update every cycle, even when out_valid=0; their contents are then don't-care for checkers.
- Mode changes:
  - op may change every cycle.
  - Each in-flight operation uses the op sampled with its own operands.
  - Back-to-back add/sub must never cross-contaminate.
- Reset mid-operation: all in-flight results are discarded and out_valid is 0 until new valid inputs have traversed the pipeline.
- Parameter legality: an illegal WIDTH/BLK/NSTG combination stops elaboration with an error.

Test Plan:
1. Reset: hold rst_n=0 while driving in_valid=1 -> out=0, co=0, ovf=0, zero=0, out_valid=0. Release rst_n, apply a single valid op -> out_valid rises exactly NSTG+1 edges after capture.
2. Add carry ripple, default params: A=0xFFFFFFFF, B=0x00000000, ci=1, op=0 -> out=0x00000000, co=1, zero=1, ovf=0. A=0x7FFFFFFF, B=1, ci=0 -> out=0x80000000, co=0, ovf=1.
3. Subtract: A=5, B=7, ci=0, op=1 -> out=0xFFFFFFFE, co=1 (borrow). A=0x80000000, B=1, ci=0 -> out=0x7FFFFFFF, ovf=1, co=0. A=9, B=4, ci=1 -> out=4, co=0.
4. Streaming: alternate add/sub every cycle with random operands at NSTG=1, 2, 4 -> every result matches the reference model at exactly NSTG+1 latency, with no gaps or misalignment. Toggle in_valid randomly -> out_valid pattern equals in_valid delayed.
5. Parameter sweep: WIDTH=16/BLK=8/NSTG=1 reproduces legacy results, e.g. 0x00FF + 0x0001 -> 0x0100, co=0. WIDTH=64/BLK=16/NSTG=3 passes an exhaustive carry-boundary set (all-ones plus 1 at each block boundary).
6. Reset mid-stream: pulse rst_n low for a partial cycle while 3 ops are in flight -> no out_valid for those ops. The next op after release is correct with nominal latency.
